// File: rtl/regfile_bypass_sb_if.sv
// regfile_bypass_sb_if: read, writeback and issue signals of the bypassing register file
interface regfile_bypass_sb_if #(
  parameter int XLEN = 32,
  parameter int AW = 5
);
  logic [AW-1:0] ra1, ra2, wa, ia;
  logic [XLEN-1:0] rd1, rd2, wd;
  logic rdy1, rdy2, we, iss, busy_any;
  modport master (output ra1, ra2, we, wa, wd, iss, ia, input rd1, rd2, rdy1, rdy2, busy_any);
  modport slave (input ra1, ra2, we, wa, wd, iss, ia, output rd1, rd2, rdy1, rdy2, busy_any);
endinterface

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: 2R/1W register file with write-first bypass and pending-write scoreboard
module regfile_bypass_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst_n,
  regfile_bypass_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  function automatic logic wr_ok(input logic [AW-1:0] a);
    return !(ZERO_REG != 0 && a == '0);
  endfunction
  // combinational reads: hardwired zero, then current writeback, then storage; bypass gated off in reset
  always_comb begin
    bus.rd1 = !wr_ok(bus.ra1) ? '0 : (rst_n && bus.we && bus.wa == bus.ra1) ? bus.wd : regs[bus.ra1];
    bus.rd2 = !wr_ok(bus.ra2) ? '0 : (rst_n && bus.we && bus.wa == bus.ra2) ? bus.wd : regs[bus.ra2];
    bus.rdy1 = !pend[bus.ra1] || (bus.we && bus.wa == bus.ra1);
    bus.rdy2 = !pend[bus.ra2] || (bus.we && bus.wa == bus.ra2);
    bus.busy_any = |pend;
  end
  // storage write, dropping writes to a hardwired zero register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.we && wr_ok(bus.wa)) begin
      regs[bus.wa] <= bus.wd;
    end
  end
  // scoreboard: writeback clears, issue sets; the later set wins on a same-address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (bus.we) pend[bus.wa] <= 1'b0;
      if (bus.iss && wr_ok(bus.ia)) pend[bus.ia] <= 1'b1;
    end
  end
endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
Parametrised successor to the core integer register file, used in the decode stage of the five-stage pipeline. It provides two combinational read ports with write-first bypass, one writeback port, and a per-register pending-write scoreboard. Each read port reports whether its operand is ready, so decode can stall on load-use and long-latency hazards without external hazard logic.

Parameters:
XLEN, 32, data width of each register.
NREG, 32, number of architectural registers. Must be a power of 2 and at least 2.
AW, $clog2(NREG), register address width. Derived; do not override.
ZERO_REG, 1, when 1, register 0 is hardwired to 0 and is never marked pending.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ra1  in  AW  read address, port 1.
ra2  in  AW  read address, port 2.
rd1  out  XLEN  read data, port 1.
rd2  out  XLEN  read data, port 2.
rdy1  out  1  port-1 operand valid (not pending, or being written back this cycle).
rdy2  out  1  port-2 operand valid.
we  in  1  writeback enable.
wa  in  AW  writeback address.
wd  in  XLEN  writeback data.
iss  in  1  issue: mark register ia pending.
ia  in  AW  destination address of the issuing instruction.
busy_any  out  1  OR of all pending bits.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers clear to 0 and all pending bits clear. While rst_n=0: rd1=rd2=0, rdy1=rdy2=1, busy_any=0.
- Storage write: on a rising clk edge with we=1, reg[wa] takes wd. A write to address 0 is dropped when ZERO_REG=1.
- Reads are combinational, zero latency.
  - rdN = wd if we=1, wa==raN, and raN is writable (write-first bypass).
  - Otherwise rdN = reg[raN].
  - With ZERO_REG=1, raN==0 always reads 0, regardless of bypass.
- Scoreboard: pend[NREG-1:0].
  - On a clock edge, iss=1 sets pend[ia].
  - On a clock edge, we=1 clears pend[wa].
  - If iss and we hit the same address in one cycle, set wins: the new producer supersedes the old one.
  - With ZERO_REG=1, pend[0] is never set.
  - With ZERO_REG=0, register 0 behaves like every other register.
- Ready outputs: rdyN = ~pend[raN] | (we & wa==raN).
  - rdyN is combinational and uses the current-cycle writeback, so a value arriving this cycle is both bypassed and reported ready.
- Ready is independent of iss in the same cycle: an issue only affects readiness from the next cycle onward.
- Writing to a register that is not pending is legal (e.g. a CSR or debug path). It updates storage, and the pending bit stays 0.
- busy_any = |pend, registered-state derived (no dependency on same-cycle inputs).
- Reset asserted mid-operation: state is cleared immediately. Any in-flight writeback on the deasserting edge is ignored only if rst_n is still low at that edge.
- Out-of-range addresses cannot occur, since NREG is a power of 2.
- No X may propagate from uninitialised storage: every entry is reset.

Test Plan:
- Reset, then read all addresses -> rd=0 and rdy=1 everywhere; busy_any=0.
- we=1, wa=5, wd=32'hDEADBEEF, ra1=5 in the same cycle -> rd1=DEADBEEF combinationally. The next cycle, with we=0, rd1 still reads DEADBEEF.
- we=1, wa=0, wd=32'h1234, ra2=0 (ZERO_REG=1) -> rd2=0 in the same cycle and after; iss=1 with ia=0 -> rdy remains 1 and busy_any remains 0.
- iss=1 with ia=7 -> next cycle rdy1=0 for ra1=7 and busy_any=1. Then we=1, wa=7, wd=9 -> rdy1=1 and rd1=9 in that cycle; next cycle pend[7]=0 and busy_any=0.
- Same cycle iss=1 ia=3 and we=1 wa=3 wd=5 with reg3 pending -> storage holds 5, pend[3] stays 1, and rdy for ra=3 is 0 on the next cycle.
- Mark regs 1, 2 and 31 pending, then pulse rst_n low asynchronously between clock edges -> rd=0, rdy=1 and busy_any=0 immediately, with no clock edge required.
